axil_reg_slave: RTL

AXI4-Lite responder (slave) providing NUM_REGS 32-bit read/write control registers, mapped at consecutive word addresses from 0x0.
It is the target that the block-design master VIP drives with single-beat AXI4LITE write/read bursts.
Register contents are exported as a flat bus, together with per-register write strobes, to the MC-Pi fabric (seed, control, sample count, and so on).
It supports one outstanding write and one outstanding read, handled independently.

---
 rtl/axil_pkg.sv | 31 +++
 rtl/axil_wstrb_merge.sv | 16 +
 rtl/axil_reg_slave.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite register slave: response codes,
// FSM state types and the byte-lane write helper.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  function automatic logic [31:0] apply_wstrb(
    input logic [31:0] old_data,
    input logic [31:0] wdata,
    input logic [3:0]  wstrb
  );
    logic [31:0] res;
    res = old_data;
    for (int unsigned b = 0; b < 4; b++) begin
      if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_wstrb_merge.sv
// Combinational byte-lane merge: lanes with WSTRB set take WDATA,
// the rest keep the old register value.
module axil_wstrb_merge
  import axil_pkg::*;
(
  input  logic [31:0] old_data,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic [31:0] merged
);

  always_comb begin
    merged = apply_wstrb(old_data, wdata, wstrb);
  end

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit control registers as a flat bus.
// Optional AXIL_REG_SLAVE_SLVERR_EN: unmapped upper address bits give SLVERR.
module axil_reg_slave
  import axil_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 4,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic [ADDR_WIDTH-1:0]    AWADDR,
  input  logic [2:0]               AWPROT,
  input  logic                     AWVALID,
  output logic                     AWREADY,
  input  logic [DATA_WIDTH-1:0]    WDATA,
  input  logic [3:0]               WSTRB,
  input  logic                     WVALID,
  output logic                     WREADY,
  output logic [1:0]               BRESP,
  output logic                     BVALID,
  input  logic                     BREADY,
  input  logic [ADDR_WIDTH-1:0]    ARADDR,
  input  logic [2:0]               ARPROT,
  input  logic                     ARVALID,
  output logic                     ARREADY,
  output logic [DATA_WIDTH-1:0]    RDATA,
  output logic [1:0]               RRESP,
  output logic                     RVALID,
  input  logic                     RREADY,
  output logic [NUM_REGS*32-1:0]   reg_out,
  output logic [NUM_REGS-1:0]      reg_wr_stb
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);

  // Readies stay low until the first edge after reset release.
  logic ready_en_q, ready_en_d;

  wr_state_t                    wr_state_q, wr_state_d;
  logic                         aw_held_q, aw_held_d;
  logic                         w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0]        aw_addr_q, aw_addr_d;
  logic [31:0]                  w_data_q, w_data_d;
  logic [3:0]                   w_strb_q, w_strb_d;
  logic                         bvalid_q, bvalid_d;
  logic [1:0]                   bresp_q, bresp_d;
  logic [NUM_REGS-1:0][31:0]    regs_q, regs_d;
  logic [NUM_REGS-1:0]          reg_wr_stb_q, reg_wr_stb_d;

  rd_state_t                    rd_state_q, rd_state_d;
  logic                         rvalid_q, rvalid_d;
  logic [31:0]                  rdata_q, rdata_d;
  logic [1:0]                   rresp_q, rresp_d;

  logic [IDX_W-1:0]             w_idx, r_idx;
  logic                         w_unmapped, r_unmapped;
  logic [31:0]                  merged_data;
  logic                         unused_bits;

  assign w_idx = aw_addr_q[2 +: IDX_W];
  assign r_idx = ARADDR[2 +: IDX_W];

`ifdef AXIL_REG_SLAVE_SLVERR_EN
  assign w_unmapped = (aw_addr_q >> (IDX_W + 2)) != '0;
  assign r_unmapped = (ARADDR >> (IDX_W + 2)) != '0;
`else
  assign w_unmapped = 1'b0;
  assign r_unmapped = 1'b0;
`endif

  assign unused_bits = ^{AWPROT, ARPROT, aw_addr_q, ARADDR};

  axil_wstrb_merge u_merge (
    .old_data (regs_q[w_idx]),
    .wdata    (w_data_q),
    .wstrb    (w_strb_q),
    .merged   (merged_data)
  );

  assign ready_en_d = 1'b1;
  assign AWREADY    = ready_en_q && (wr_state_q == W_IDLE) && !aw_held_q;
  assign WREADY     = ready_en_q && (wr_state_q == W_IDLE) && !w_held_q;
  assign ARREADY    = ready_en_q && (rd_state_q == R_IDLE);
  assign BVALID     = bvalid_q;
  assign BRESP      = bresp_q;
  assign RVALID     = rvalid_q;
  assign RRESP      = rresp_q;
  assign RDATA      = rdata_q;
  assign reg_out    = regs_q;
  assign reg_wr_stb = reg_wr_stb_q;

  // Commit fires the edge after both AW and W are held, regardless of order.
  always_comb begin
    wr_state_d   = wr_state_q;
    aw_held_d    = aw_held_q;
    w_held_d     = w_held_q;
    aw_addr_d    = aw_addr_q;
    w_data_d     = w_data_q;
    w_strb_d     = w_strb_q;
    bvalid_d     = bvalid_q;
    bresp_d      = bresp_q;
    regs_d       = regs_q;
    reg_wr_stb_d = '0;
    case (wr_state_q)
      W_IDLE: begin
        if (AWVALID && AWREADY) begin
          aw_held_d = 1'b1;
          aw_addr_d = AWADDR;
        end
        if (WVALID && WREADY) begin
          w_held_d = 1'b1;
          w_data_d = WDATA;
          w_strb_d = WSTRB;
        end
        if (aw_held_q && w_held_q) begin
          if (w_unmapped) begin
            bresp_d = RESP_SLVERR;
          end else begin
            regs_d[w_idx]       = merged_data;
            reg_wr_stb_d[w_idx] = 1'b1;
            bresp_d             = RESP_OKAY;
          end
          bvalid_d   = 1'b1;
          wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (BREADY) begin
          bvalid_d   = 1'b0;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      R_IDLE: begin
        if (ARVALID && ARREADY) begin
          if (r_unmapped) begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end else begin
            rdata_d = regs_q[r_idx];
            rresp_d = RESP_OKAY;
          end
          rvalid_d   = 1'b1;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (RREADY) begin
          rvalid_d   = 1'b0;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ready_en_q   <= 1'b0;
      wr_state_q   <= W_IDLE;
      aw_held_q    <= 1'b0;
      w_held_q     <= 1'b0;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      regs_q       <= '0;
      reg_wr_stb_q <= '0;
      rd_state_q   <= R_IDLE;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      rresp_q      <= RESP_OKAY;
    end else begin
      ready_en_q   <= ready_en_d;
      wr_state_q   <= wr_state_d;
      aw_held_q    <= aw_held_d;
      w_held_q     <= w_held_d;
      aw_addr_q    <= aw_addr_d;
      w_data_q     <= w_data_d;
      w_strb_q     <= w_strb_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      regs_q       <= regs_d;
      reg_wr_stb_q <= reg_wr_stb_d;
      rd_state_q   <= rd_state_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
    end
  end

endmodule
